sum_block_averager: RTL and testbench
=====================================

// Module: sum_block_averager
// PURPOSE
//  Downstream consumer of the 16+16->17-bit adder stage. Accepts a stream of
//  17-bit sums over a valid/ready handshake and accumulates blocks of
//  2**N_LOG2 samples. Emits the block total and the block average (truncated
//  or rounded) over a second valid/ready handshake.
//  Feeds display/result logic that needs one averaged value per block.
// PARAMETERS
//  IN_W    17  input sum width (adder output width)
//  N_LOG2  2   log2 of samples per block; legal range 1..8
//  ROUND   0   0 = average truncates; 1 = round-half-up
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              async reset, active-high
//  clear      in   1              sync abort of current block, drops any held result
//  in_valid   in   1              sum_in valid
//  in_ready   out  1              block can accept sum_in
//  sum_in     in   IN_W           unsigned sum from adder stage
//  out_valid  out  1              avg_out/acc_out valid
//  out_ready  in   1              downstream accepts result
//  avg_out    out  IN_W           block average
//  acc_out    out  IN_W+N_LOG2    block total (full width, never overflows)
//  count      out  N_LOG2         samples accepted in current block
// BEHAVIOUR
//  - Reset: state=ACCUM; acc, count, avg_out, acc_out = 0; out_valid = 0;
//    in_ready = 1 once rst deasserts.
//  - Reset mid-block or mid-HOLD: partial sums and held results are discarded.
//  - FSM has two states: ACCUM and HOLD.
//  - ACCUM state:
//    - in_ready = 1, out_valid = 0.
//    - Accept when in_valid & in_ready: acc <= acc + sum_in; count++.
//    - Width rule: all sums are unsigned, IN_W+N_LOG2 bits wide; no wrap is possible.
//    - When the accepted sample is the last one (count == 2**N_LOG2-1):
//      - Register acc_out = acc + sum_in, and avg_out from that total.
//      - Clear acc and count; go to HOLD.
//    - Result latency: out_valid rises the cycle after the last sample is accepted.
//  - Average calculation:
//    - ROUND=0: avg_out = total >> N_LOG2.
//    - ROUND=1: avg_out = (total + 2**(N_LOG2-1)) >> N_LOG2, computed
//      IN_W+N_LOG2+1 bits wide; the result never exceeds 2**IN_W-1.
//  - HOLD state:
//    - out_valid = 1, in_ready = 0.
//    - avg_out and acc_out stay stable until the handshake completes.
//    - On out_ready: out_valid drops next cycle; go to ACCUM. No bubble is
//      required beyond this one cycle.
//  - clear:
//    - Highest priority after rst.
//    - Any state -> ACCUM with acc = 0, count = 0, out_valid = 0.
//    - A sample offered in the same cycle is NOT accepted.
//    - A result handshaking in the same cycle is dropped.
//  - in_valid without in_ready: no state change.
//  - Upstream must hold sum_in stable while in_valid is high and in_ready is low.
//  - avg_out/acc_out keep their last value after the handshake until the next
//    result is registered.
// TESTING
//  - N_LOG2=2, ROUND=0, sums 10,20,30,41 back-to-back, out_ready=1
//    -> acc_out=101, avg_out=25, out_valid for exactly 1 cycle.
//  - ROUND=1, sums 1,1,1,3 -> acc_out=6, avg_out=2.
//    Same sums with ROUND=0 -> avg_out=1.
//  - Four sums of 0x1FFFF -> acc_out=0x7FFFC, avg_out=0x1FFFF (no overflow).
//  - out_ready low for 5 cycles after a result -> out_valid, avg_out and
//    acc_out stable; in_ready=0.
//    A 5th in_valid sample is not accepted until after the handshake.
//  - Reset mid-block: 2 samples of 100, pulse rst, then 4 samples of 8
//    -> acc_out=32, avg_out=8.
//  - clear asserted with in_valid on sample 3 -> count=0, sample dropped.
//    Next 4 samples form a fresh block.

Source files
------------

// File: rtl/sum_block_averager.sv
// sum_block_averager
// Collects blocks of 2**N_LOG2 unsigned sums from the adder stage and reports
// each block's total and its average, truncated or rounded half-up. Results
// are held on the output handshake until downstream accepts them.
module sum_block_averager #(
  parameter int IN_W   = 17,
  parameter int N_LOG2 = 2,
  parameter int ROUND  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          sum_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IN_W-1:0]          avg_out,
  output logic [IN_W+N_LOG2-1:0]   acc_out,
  output logic [N_LOG2-1:0]        count
);

  // The accumulator is N_LOG2 bits wider than a sample, so a full block of
  // maximum-valued sums fits without wrapping.
  localparam int ACC_W = IN_W + N_LOG2;

  // Half of one LSB of the average, added before the shift when rounding.
  localparam logic [ACC_W:0] HALF_LSB = (ACC_W + 1)'(1) << (N_LOG2 - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [ACC_W-1:0]        r_acc;
  logic [N_LOG2-1:0]       r_count;
  logic [IN_W-1:0]         r_avg;
  logic [ACC_W-1:0]        r_acc_out;

  logic                    w_accept;
  logic                    w_last;
  logic [ACC_W-1:0]        w_total;

  // Average of a block total. The extra headroom bit keeps the rounding add
  // from wrapping; after the shift the value always fits in IN_W bits because
  // the largest total is (2**IN_W-1) * 2**N_LOG2.
  function automatic logic [IN_W-1:0] f_average(input logic [ACC_W-1:0] total);
    logic [ACC_W:0] wide;
    wide = {1'b0, total};
    if (ROUND != 0) begin
      wide = wide + HALF_LSB;
    end
    return IN_W'(wide >> N_LOG2);
  endfunction

  // Handshake decode: clear wins over a simultaneous sample.
  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);
  assign w_accept  = in_valid & in_ready & ~clear;
  assign w_last    = (r_count == {N_LOG2{1'b1}});
  assign w_total   = r_acc + ACC_W'(sum_in);

  assign avg_out = r_avg;
  assign acc_out = r_acc_out;
  assign count   = r_count;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: accumulate until the block closes, then hold the result
  // until it is taken. clear aborts from either state.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept && w_last) begin
            w_next_state = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            w_next_state = ST_ACCUM;
          end
        end
        default: w_next_state = ST_ACCUM;
      endcase
    end
  end

  // Block accumulator and sample counter; both restart after the last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc   <= '0;
        r_count <= '0;
      end else begin
        r_acc   <= w_total;
        r_count <= r_count + N_LOG2'(1);
      end
    end
  end

  // Result registers: loaded only when a block closes, so they keep the last
  // result through HOLD and after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_out <= '0;
      r_avg     <= '0;
    end else if (w_accept && w_last) begin
      r_acc_out <= w_total;
      r_avg     <= f_average(w_total);
    end
  end

endmodule

// File: tb/tb_sum_block_averager.sv
// Bench for sum_block_averager: a truncating and a rounding instance share
// one stimulus stream; a scoreboard of expected block results is checked
// whenever a result handshake occurs.
module tb_sum_block_averager;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [16:0] sum_in = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_t, out_valid_t, in_ready_r, out_valid_r;
  logic [16:0] avg_t, avg_r;
  logic [18:0] acc_t, acc_r;
  logic [1:0]  count_t, count_r;

  typedef struct {
    logic [18:0] acc;
    logic [16:0] avg_t;
    logic [16:0] avg_r;
  } exp_t;

  exp_t        sb_q[$];
  logic [19:0] m_acc = '0;
  int          m_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  sum_block_averager #(.IN_W(17), .N_LOG2(2), .ROUND(0)) u_trunc (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_t), .sum_in(sum_in), .out_valid(out_valid_t),
    .out_ready(out_ready), .avg_out(avg_t), .acc_out(acc_t), .count(count_t)
  );

  sum_block_averager #(.IN_W(17), .N_LOG2(2), .ROUND(1)) u_round (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_r), .sum_in(sum_in), .out_valid(out_valid_r),
    .out_ready(out_ready), .avg_out(avg_r), .acc_out(acc_r), .count(count_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one sample and wait (bounded) until it is accepted; updates the model.
  task automatic send(input logic [16:0] v);
    int  t;
    bit  took;
    logic [19:0] s;
    exp_t e;
    t = 0;
    took = 1'b0;
    in_valid = 1'b1;
    sum_in = v;
    while (!took && t < 50) begin
      @(negedge clk);
      if (in_ready_t && !clear && !rst) took = 1'b1;
      t++;
    end
    if (!took) begin
      chk("send_timeout", 64'd0, 64'd1);
    end else begin
      s = m_acc + 20'(v);
      m_cnt++;
      if (m_cnt == 4) begin
        e.acc   = s[18:0];
        e.avg_t = 17'(s >> 2);
        e.avg_r = 17'((s + 20'd2) >> 2);
        sb_q.push_back(e);
        m_acc = '0;
        m_cnt = 0;
      end else begin
        m_acc = s;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard check on every result handshake.
  always @(negedge clk) begin
    if (!rst && !clear && out_valid_t && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("acc_trunc", 64'(acc_t), 64'(e.acc));
        chk("avg_trunc", 64'(avg_t), 64'(e.avg_t));
        chk("acc_round", 64'(acc_r), 64'(e.acc));
        chk("avg_round", 64'(avg_r), 64'(e.avg_r));
        chk("valid_round", 64'(out_valid_r), 64'd1);
      end
    end
  end

  initial begin
    idle(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_t), 64'd0);
    chk("rst_in_ready", 64'(in_ready_t), 64'd1);
    chk("rst_count", 64'(count_t), 64'd0);
    chk("rst_acc_out", 64'(acc_t), 64'd0);
    chk("rst_avg_out", 64'(avg_t), 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back block, out_valid lasts one cycle
    send(17'd10);
    send(17'd20);
    chk("count_mid", 64'(count_t), 64'd2);
    send(17'd30);
    send(17'd41);
    @(negedge clk);
    chk("ov_first_cycle", 64'(out_valid_t), 64'd1);
    chk("in_ready_hold", 64'(in_ready_t), 64'd0);
    @(negedge clk);
    chk("ov_second_cycle", 64'(out_valid_t), 64'd0);
    chk("acc_101", 64'(acc_t), 64'd101);
    chk("avg_25", 64'(avg_t), 64'd25);
    @(posedge clk);
    #1;

    // Rounding versus truncation; results persist after the handshake
    send(17'd1);
    send(17'd1);
    send(17'd1);
    send(17'd3);
    idle(2);
    @(negedge clk);
    chk("held_acc_6", 64'(acc_t), 64'd6);
    chk("held_avg_trunc_1", 64'(avg_t), 64'd1);
    chk("held_avg_round_2", 64'(avg_r), 64'd2);
    @(posedge clk);
    #1;

    // Full-scale samples: widest total, no overflow
    repeat (4) send(17'h1FFFF);
    idle(2);
    @(negedge clk);
    chk("max_acc", 64'(acc_t), 64'h7FFFC);
    chk("max_avg_trunc", 64'(avg_t), 64'h1FFFF);
    chk("max_avg_round", 64'(avg_r), 64'h1FFFF);
    @(posedge clk);
    #1;

    // Downstream stall for 5 cycles with a pending 5th sample
    out_ready = 1'b0;
    send(17'd50);
    send(17'd60);
    send(17'd70);
    send(17'd81);
    in_valid = 1'b1;
    sum_in = 17'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid_t), 64'd1);
      chk("stall_in_ready", 64'(in_ready_t), 64'd0);
      chk("stall_acc", 64'(acc_t), 64'd261);
      chk("stall_avg", 64'(avg_t), 64'd65);
      chk("stall_count", 64'(count_t), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(17'd7);
    chk("post_stall_count", 64'(count_t), 64'd1);
    send(17'd9);
    send(17'd11);
    send(17'd13);
    idle(2);

    // Reset mid-block discards partial sums
    send(17'd100);
    send(17'd100);
    rst = 1'b1;
    m_acc = '0;
    m_cnt = 0;
    idle(1);
    rst = 1'b0;
    chk("rst_mid_count", 64'(count_t), 64'd0);
    repeat (4) send(17'd8);
    idle(2);
    @(negedge clk);
    chk("rst_mid_acc_32", 64'(acc_t), 64'd32);
    chk("rst_mid_avg_8", 64'(avg_t), 64'd8);
    @(posedge clk);
    #1;

    // clear on the third sample drops it and restarts the block
    send(17'd5);
    send(17'd6);
    clear = 1'b1;
    in_valid = 1'b1;
    sum_in = 17'd999;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    m_acc = '0;
    m_cnt = 0;
    @(negedge clk);
    chk("clear_count", 64'(count_t), 64'd0);
    chk("clear_ov", 64'(out_valid_t), 64'd0);
    @(posedge clk);
    #1;
    send(17'd2);
    send(17'd2);
    send(17'd2);
    send(17'd4);
    idle(2);
    @(negedge clk);
    chk("clear_blk_acc", 64'(acc_t), 64'd10);
    chk("clear_blk_trunc", 64'(avg_t), 64'd2);
    chk("clear_blk_round", 64'(avg_r), 64'd3);
    @(posedge clk);
    #1;

    // Random blocks with idle gaps
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 4; k++) begin
        idle($urandom_range(0, 2));
        send(17'($urandom_range(0, 131071)));
      end
    end

    // Drain
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) idle(1);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
